// File: rtl/st7735_spi_tx.sv
// st7735_spi_tx
// Byte-level SPI (mode 0, MSB first) transmitter for the ST7735 LCD panel.
// Bytes arrive from the init/pixel sequencer over a valid/ready handshake and
// are shifted out on the panel pins with a programmable SCL half-period.
//
// Parameters:
//   CLK_DIV   SCL half-period in clk cycles (>= 1).
// Ports:
//   clk       system clock, rising-edge logic
//   rst       synchronous active-high reset
//   tx_data   byte to send (sampled on handshake only)
//   tx_dc     0 = command, 1 = data (sampled with tx_data)
//   tx_valid  upstream has a byte
//   tx_ready  block can accept a byte this cycle
//   busy      transfer in progress
//   lcd_scl   SPI clock, idles low
//   lcd_sda   SPI data, MSB first
//   lcd_cs    chip select, active low
//   lcd_dc    data/command select to the panel
module st7735_spi_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_dc,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       lcd_scl,
  output logic       lcd_sda,
  output logic       lcd_cs,
  output logic       lcd_dc
);

  localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_END
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  // Only the seven bits still to be sent; bit 7 goes straight to lcd_sda on load.
  logic [6:0]    shift_q;
  logic          scl_q;
  logic          sda_q;
  logic          cs_q;
  logic          dc_q;

  logic          cnt_last;
  logic          accept;

  assign cnt_last = (cnt_q == CNT_LAST);

  // Ready in IDLE, or in the last END cycle so back-to-back bytes keep CS low.
  assign tx_ready = !rst && ((state_q == S_IDLE) || ((state_q == S_END) && cnt_last));
  assign accept   = tx_valid && tx_ready;
  assign busy     = (state_q != S_IDLE);

  assign lcd_scl  = scl_q;
  assign lcd_sda  = sda_q;
  assign lcd_cs   = cs_q;
  assign lcd_dc   = dc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      scl_q   <= 1'b0;
      sda_q   <= 1'b0;
      cs_q    <= 1'b1;
      dc_q    <= 1'b0;
    end else if (accept) begin
      // accept can only be true in IDLE or the final END cycle; both load alike.
      shift_q <= tx_data[6:0];
      bit_q   <= 3'd7;
      sda_q   <= tx_data[7];
      dc_q    <= tx_dc;
      cs_q    <= 1'b0;
      scl_q   <= 1'b0;
      cnt_q   <= '0;
      state_q <= S_SETUP;
    end else begin
      case (state_q)
        S_IDLE: begin
          cs_q  <= 1'b1;
          scl_q <= 1'b0;
          cnt_q <= '0;
        end
        S_SETUP, S_LOW: begin
          if (cnt_last) begin
            scl_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_HIGH;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_HIGH: begin
          if (cnt_last) begin
            scl_q <= 1'b0;
            cnt_q <= '0;
            if (bit_q != 3'd0) begin
              // Next bit changes on the falling edge, a full half-period before the rise.
              bit_q   <= bit_q - 1'b1;
              sda_q   <= shift_q[6];
              shift_q <= {shift_q[5:0], 1'b0};
              state_q <= S_LOW;
            end else begin
              state_q <= S_END;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_END: begin
          if (cnt_last) begin
            cs_q    <= 1'b1;
            sda_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_st7735_spi_tx.sv
// Testbench for st7735_spi_tx: two instances (CLK_DIV=4 and CLK_DIV=1) are
// driven from one process and checked every cycle against a timeline model
// that derives the pin values from the cycle count since the last accept.
module tb_st7735_spi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst;
  logic [1:0] valid;
  logic [1:0] dcin;
  logic [7:0] data [2];
  logic [1:0] ready, busy, scl, sda, cs, dco;

  st7735_spi_tx #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst[0]), .tx_data(data[0]), .tx_dc(dcin[0]), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .busy(busy[0]), .lcd_scl(scl[0]), .lcd_sda(sda[0]),
    .lcd_cs(cs[0]), .lcd_dc(dco[0])
  );

  st7735_spi_tx #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst[1]), .tx_data(data[1]), .tx_dc(dcin[1]), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .busy(busy[1]), .lcd_scl(scl[1]), .lcd_sda(sda[1]),
    .lcd_cs(cs[1]), .lcd_dc(dco[1])
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit armed = 1'b0;

  // Model: k = cycles since the accept edge (0 = idle), byte and dc in flight.
  int         k     [2];
  logic [7:0] mb    [2];
  logic       mdc   [2];
  int         acc   [2];
  int         pacc  [2];

  // Measurements taken from the pins, compared against literal expectations.
  int          rises    [2];
  logic [15:0] cap      [2];
  int          lowrun   [2];
  int          hirun    [2];
  int          last_low [2];
  int          last_hi  [2];
  int          lrise    [2];
  int          gap      [2];
  logic        pscl     [2];
  logic        pcs      [2];

  function automatic int divof(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // {tx_ready, busy, lcd_cs, lcd_scl, lcd_sda, lcd_dc}
  function automatic logic [5:0] model_pins(input int i);
    int   dv, p, bi;
    logic r, bs, c, s, d;
    dv = divof(i);
    r  = !rst[i] && (k[i] == 0 || k[i] == 17 * dv);
    if (k[i] == 0) begin
      bs = 1'b0; c = 1'b1; s = 1'b0; d = 1'b0;
    end else begin
      p  = (k[i] - 1) / dv;           // half-period index 0..16
      bs = 1'b1;
      c  = 1'b0;
      s  = (p >= 1 && p <= 15 && (p % 2) == 1);
      bi = 7 - (((p > 15) ? 15 : p) / 2);
      d  = mb[i][bi];
    end
    return {r, bs, c, s, d, mdc[i]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  // One clock: from a falling edge to the next falling edge.
  task automatic tick();
    logic [5:0] a;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      int  dv;
      bit  rdy;
      dv  = divof(i);
      rdy = !rst[i] && (k[i] == 0 || k[i] == 17 * dv);
      if (rst[i]) begin
        k[i] = 0; mdc[i] = 1'b0; mb[i] = 8'h00;
      end else if (valid[i] && rdy) begin
        k[i] = 1; mb[i] = data[i]; mdc[i] = dcin[i];
        pacc[i] = acc[i]; acc[i] = cyc;
      end else if (k[i] == 17 * dv) begin
        k[i] = 0;
      end else if (k[i] > 0) begin
        k[i]++;
      end
    end
    #1;
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        a = {ready[i], busy[i], cs[i], scl[i], sda[i], dco[i]};
        check($sformatf("pins%0d", i), {26'd0, a}, {26'd0, model_pins(i)});
        if (scl[i] && !pscl[i]) begin
          rises[i]++;
          cap[i]   = {cap[i][14:0], sda[i]};
          gap[i]   = cyc - lrise[i];
          lrise[i] = cyc;
        end
        pscl[i] = scl[i];
        if (!cs[i]) begin
          if (pcs[i]) last_hi[i] = hirun[i];
          lowrun[i]++;
          hirun[i] = 0;
        end else begin
          if (!pcs[i]) last_low[i] = lowrun[i];
          hirun[i]++;
          lowrun[i] = 0;
        end
        pcs[i] = cs[i];
      end
    end
    @(negedge clk);
  endtask

  // Present a byte and hold valid until it is taken; returns with valid still 1.
  task automatic push(input int i, input logic [7:0] b, input logic d);
    int n;
    data[i] = b; dcin[i] = d; valid[i] = 1'b1;
    n = 0;
    while (!ready[i] && n < 500) begin
      tick();
      n++;
    end
    if (!ready[i]) timeout($sformatf("push%0d", i));
    tick();
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (busy[i] && n < 500) begin
      tick();
      n++;
    end
    if (busy[i]) timeout($sformatf("idle%0d", i));
    tick();
  endtask

  int base, abase;

  initial begin
    for (int i = 0; i < 2; i++) begin
      k[i] = 0; mb[i] = 8'h00; mdc[i] = 1'b0; acc[i] = 0; pacc[i] = 0;
      rises[i] = 0; cap[i] = 16'h0; lowrun[i] = 0; hirun[i] = 0;
      last_low[i] = 0; last_hi[i] = 0; lrise[i] = 0; gap[i] = 0;
      pscl[i] = 1'b0; pcs[i] = 1'b1;
      data[i] = 8'h00;
    end
    rst = 2'b11; valid = 2'b00; dcin = 2'b00;
    @(negedge clk);
    tick();
    armed = 1'b1;
    tick();
    check("rst_ready", {30'd0, ready}, 32'd0);
    check("rst_cs", {30'd0, cs}, 32'd3);
    check("rst_busy", {30'd0, busy}, 32'd0);
    rst = 2'b00;
    #1;
    check("ready_after_rst", {30'd0, ready}, 32'd3);

    // Single byte 0xA5, command.
    base = rises[0];
    push(0, 8'hA5, 1'b0);
    valid[0] = 1'b0;
    wait_idle(0);
    check("a5_rises", rises[0] - base, 8);
    check("a5_bits", {24'd0, cap[0][7:0]}, 32'hA5);
    check("a5_cs_low", last_low[0], 68);
    check("a5_ready", {31'd0, ready[0]}, 1);

    // Back-to-back 0x2A (cmd) then 0x00 (data), valid held high.
    base = rises[0];
    push(0, 8'h2A, 1'b0);
    push(0, 8'h00, 1'b1);
    valid[0] = 1'b0;
    check("b2b_period", acc[0] - pacc[0], 68);
    wait_idle(0);
    check("b2b_rises", rises[0] - base, 16);
    check("b2b_bits", {16'd0, cap[0]}, 32'h2A00);
    check("b2b_cs_low", last_low[0], 136);

    // Busy-hold: tx_data churns while 0x3C is in flight.
    base = rises[0];
    push(0, 8'h3C, 1'b0);
    abase = acc[0];
    begin
      int n;
      n = 0;
      while (!ready[0] && n < 200) begin
        data[0] = 8'($urandom);
        dcin[0] = 1'($urandom);
        tick();
        n++;
      end
      if (!ready[0]) timeout("hold_ready");
    end
    valid[0] = 1'b0;
    wait_idle(0);
    check("hold_no_accept", acc[0], abase);
    check("hold_bits", {24'd0, cap[0][7:0]}, 32'h3C);
    check("hold_rises", rises[0] - base, 8);

    // Reset after the third SCL rise of a 0xFF data byte.
    base = rises[0];
    push(0, 8'hFF, 1'b1);
    valid[0] = 1'b0;
    begin
      int n;
      n = 0;
      while (rises[0] - base < 3 && n < 300) begin
        tick();
        n++;
      end
      if (rises[0] - base < 3) timeout("rst_mid_rise");
    end
    rst[0] = 1'b1;
    tick();
    check("mid_rst_pins", {28'd0, cs[0], scl[0], sda[0], dco[0]}, 32'b1000);
    rst[0] = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, ready[0]}, 1);
    base = rises[0];
    push(0, 8'hFF, 1'b0);
    valid[0] = 1'b0;
    wait_idle(0);
    check("ff_bits", {24'd0, cap[0][7:0]}, 32'hFF);
    check("ff_rises", rises[0] - base, 8);

    // CLK_DIV=1 instance, byte 0x81.
    base = rises[1];
    push(1, 8'h81, 1'b0);
    valid[1] = 1'b0;
    wait_idle(1);
    check("div1_bits", {24'd0, cap[1][7:0]}, 32'h81);
    check("div1_rises", rises[1] - base, 8);
    check("div1_len", last_low[1], 17);
    check("div1_scl_period", gap[1], 2);

    // Two bytes separated by a 5-cycle idle gap.
    push(0, 8'h11, 1'b0);
    valid[0] = 1'b0;
    wait_idle(0);
    repeat (5) tick();
    push(0, 8'h22, 1'b1);
    valid[0] = 1'b0;
    check("gap_cs_high", {31'd0, (last_hi[0] >= 1)}, 1);
    wait_idle(0);
    check("gap_bits", {24'd0, cap[0][7:0]}, 32'h22);

    // Random traffic with occasional resets on both instances.
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < 2; i++) begin
        rst[i]   = ($urandom_range(0, 299) == 0);
        valid[i] = ($urandom_range(0, 3) != 0);
        data[i]  = 8'($urandom);
        dcin[i]  = 1'($urandom);
      end
      tick();
    end
    valid = 2'b00;
    rst   = 2'b00;
    repeat (80) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
